scanline_mixer: RTL and testbench

- Post-processing stage directly downstream of the line-doubling scandoubler.
- Consumes its doubled-rate RGB, sync and blank outputs, qualified by its output pixel enable.
- Darkens every odd output line by a selectable amount to emulate CRT scanlines.
- Blacks out RGB during blanking and re-aligns sync/blank with the processed colour through a fixed 2-enable pipeline before the video output mux.

---
 rtl/scanline_mixer.sv | 135 +++++++++++++
 tb/tb_scanline_mixer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scanline_mixer.sv
// CRT scanline emulation behind the scandoubler: darkens odd output lines, blanks RGB,
// and keeps sync/blank aligned with the processed colour through a 2-enable pipeline.
module scanline_mixer #(
    parameter int HALF_DEPTH = 0,
    localparam int DW = (HALF_DEPTH != 0) ? 4 : 8
) (
    input  logic          clk_sys,
    input  logic          reset_n,
    input  logic          ce_pix,
    input  logic [1:0]    scanlines,
    input  logic          hs_in,
    input  logic          vs_in,
    input  logic          hb_in,
    input  logic          vb_in,
    input  logic [DW-1:0] r_in,
    input  logic [DW-1:0] g_in,
    input  logic [DW-1:0] b_in,
    output logic          hs_out,
    output logic          vs_out,
    output logic          hb_out,
    output logic          vb_out,
    output logic [DW-1:0] r_out,
    output logic [DW-1:0] g_out,
    output logic [DW-1:0] b_out,
    output logic          line_odd
);

    logic          hs_prev;
    logic          vs_prev;
    logic [1:0]    lvl;
    logic          hs_fall;
    logic          vs_rise;

    logic [DW-1:0] r_s1;
    logic [DW-1:0] g_s1;
    logic [DW-1:0] b_s1;
    logic          hs_s1;
    logic          vs_s1;
    logic          hb_s1;
    logic          vb_s1;
    logic          dim_s1;
    logic          blank_s1;
    logic [1:0]    lvl_s1;

    function automatic logic [DW-1:0] dim_chan(input logic [DW-1:0] c, input logic [1:0] l);
        logic [DW-1:0] quarter;
        quarter = c >> 2;
        case (l)
            2'd1:    dim_chan = c - quarter;
            2'd2:    dim_chan = c >> 1;
            2'd3:    dim_chan = quarter;
            default: dim_chan = c;
        endcase
    endfunction

    function automatic logic [DW-1:0] mix_chan(input logic [DW-1:0] c, input logic blank,
                                               input logic dim, input logic [1:0] l);
        if (blank)
            mix_chan = '0;
        else if (dim)
            mix_chan = dim_chan(c, l);
        else
            mix_chan = c;
    endfunction

    assign hs_fall = hs_prev & ~hs_in;
    assign vs_rise = ~vs_prev & vs_in;

    // Frame/line tracking: vs rise restarts parity and latches the dim level for the new frame.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_prev  <= 1'b0;
            vs_prev  <= 1'b0;
            line_odd <= 1'b0;
            lvl      <= 2'd0;
        end else if (ce_pix) begin
            hs_prev <= hs_in;
            vs_prev <= vs_in;
            if (vs_rise) begin
                line_odd <= 1'b0;
                lvl      <= scanlines;
            end else if (hs_fall) begin
                line_odd <= ~line_odd;
            end
        end
    end

    // Level travels with dim so a frame boundary never mixes old dim with new level.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            r_s1     <= '0;
            g_s1     <= '0;
            b_s1     <= '0;
            hs_s1    <= 1'b0;
            vs_s1    <= 1'b0;
            hb_s1    <= 1'b0;
            vb_s1    <= 1'b0;
            dim_s1   <= 1'b0;
            blank_s1 <= 1'b0;
            lvl_s1   <= 2'd0;
        end else if (ce_pix) begin
            r_s1     <= r_in;
            g_s1     <= g_in;
            b_s1     <= b_in;
            hs_s1    <= hs_in;
            vs_s1    <= vs_in;
            hb_s1    <= hb_in;
            vb_s1    <= vb_in;
            dim_s1   <= line_odd & (lvl != 2'd0);
            blank_s1 <= hb_in | vb_in;
            lvl_s1   <= lvl;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            hs_out <= 1'b0;
            vs_out <= 1'b0;
            hb_out <= 1'b0;
            vb_out <= 1'b0;
            r_out  <= '0;
            g_out  <= '0;
            b_out  <= '0;
        end else if (ce_pix) begin
            hs_out <= hs_s1;
            vs_out <= vs_s1;
            hb_out <= hb_s1;
            vb_out <= vb_s1;
            r_out  <= mix_chan(r_s1, blank_s1, dim_s1, lvl_s1);
            g_out  <= mix_chan(g_s1, blank_s1, dim_s1, lvl_s1);
            b_out  <= mix_chan(b_s1, blank_s1, dim_s1, lvl_s1);
        end
    end

endmodule

// File: tb/tb_scanline_mixer.sv
// Directed bench for scanline_mixer: an 8-bit and a 4-bit instance share sync/control stimulus.
module tb_scanline_mixer;

    logic       clk_sys = 1'b0;
    logic       reset_n;
    logic       ce_pix;
    logic [1:0] scanlines;
    logic       hs_in, vs_in, hb_in, vb_in;
    logic [7:0] r_in, g_in, b_in;
    logic [3:0] r4_in, g4_in, b4_in;

    logic       hs_out, vs_out, hb_out, vb_out, line_odd;
    logic [7:0] r_out, g_out, b_out;
    logic       hs4_out, vs4_out, hb4_out, vb4_out, line_odd4;
    logic [3:0] r4_out, g4_out, b4_out;

    int checks = 0;
    int errors = 0;

    always #5 clk_sys = ~clk_sys;

    scanline_mixer #(.HALF_DEPTH(0)) dut8 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .scanlines(scanlines),
        .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
        .r_in(r_in), .g_in(g_in), .b_in(b_in),
        .hs_out(hs_out), .vs_out(vs_out), .hb_out(hb_out), .vb_out(vb_out),
        .r_out(r_out), .g_out(g_out), .b_out(b_out), .line_odd(line_odd)
    );

    scanline_mixer #(.HALF_DEPTH(1)) dut4 (
        .clk_sys(clk_sys), .reset_n(reset_n), .ce_pix(ce_pix), .scanlines(scanlines),
        .hs_in(hs_in), .vs_in(vs_in), .hb_in(hb_in), .vb_in(vb_in),
        .r_in(r4_in), .g_in(g4_in), .b_in(b4_in),
        .hs_out(hs4_out), .vs_out(vs4_out), .hb_out(hb4_out), .vb_out(vb4_out),
        .r_out(r4_out), .g_out(g4_out), .b_out(b4_out), .line_odd(line_odd4)
    );

    task automatic en();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic set_colour(input logic [7:0] c8, input logic [3:0] c4);
        r_in = c8; g_in = c8; b_in = c8;
        r4_in = c4; g4_in = c4; b4_in = c4;
    endtask

    task automatic start_frame(input logic [1:0] s);
        scanlines = s; vs_in = 1'b1; hs_in = 1'b0;
        en();
        vs_in = 1'b0;
        en();
    endtask

    // hs pulse, then two more enables so the new parity reaches the outputs
    task automatic next_line();
        hs_in = 1'b1; en();
        hs_in = 1'b0; en();
        en(); en();
    endtask

    task automatic test_reset();
        reset_n = 1'b0; ce_pix = 1'b1; scanlines = 2'd2;
        hs_in = 0; vs_in = 0; hb_in = 0; vb_in = 0;
        set_colour(8'd200, 4'd15);
        #3;
        checks++;
        if ({hs_out, vs_out, hb_out, vb_out, line_odd, r_out, g_out, b_out} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want 0",
                     {hs_out, vs_out, hb_out, vb_out, line_odd, r_out, g_out, b_out});
        end
        en(); en();
        reset_n = 1'b1;
    endtask

    task automatic test_no_vs();
        for (int k = 1; k <= 4; k++) begin
            next_line();
            en();
            checks++;
            if (line_odd !== k[0]) begin
                errors++;
                $display("FAIL novs_parity line %0d got %b want %b", k, line_odd, k[0]);
            end
            checks++;
            if ({r_out, g_out, b_out} !== {3{8'd200}}) begin
                errors++;
                $display("FAIL novs_colour line %0d got %0d want 200", k, r_out);
            end
        end
    endtask

    task automatic test_lvl2_lines();
        start_frame(2'd2);
        checks++;
        if (line_odd !== 1'b0) begin
            errors++;
            $display("FAIL vs_parity_clear got %b want 0", line_odd);
        end
        for (int k = 1; k <= 3; k++) begin
            logic [7:0] want;
            want = k[0] ? 8'd100 : 8'd200;
            hs_in = 1'b1; en();
            checks++;
            if (hs_out !== 1'b0) begin
                errors++;
                $display("FAIL hs_latency_early got %b want 0", hs_out);
            end
            hs_in = 1'b0; en();
            checks++;
            if (hs_out !== 1'b1) begin
                errors++;
                $display("FAIL hs_latency got %b want 1", hs_out);
            end
            en();
            checks++;
            if (r_out !== (k[0] ? 8'd200 : 8'd100)) begin
                errors++;
                $display("FAIL dim_latency_early line %0d got %0d want %0d",
                         k, r_out, k[0] ? 8'd200 : 8'd100);
            end
            en();
            checks++;
            if ({r_out, g_out, b_out} !== {3{want}}) begin
                errors++;
                $display("FAIL lvl2_line line %0d got %0d want %0d", k, r_out, want);
            end
            for (int i = 0; i < 6; i++) en();
        end
        // colour change appears after its second enable
        set_colour(8'd40, 4'd15);
        en();
        checks++;
        if (r_out !== 8'd100) begin
            errors++;
            $display("FAIL colour_latency_early got %0d want 100", r_out);
        end
        en();
        checks++;
        if (r_out !== 8'd20) begin
            errors++;
            $display("FAIL colour_latency got %0d want 20", r_out);
        end
    endtask

    task automatic test_levels();
        set_colour(8'd255, 4'd15);
        start_frame(2'd1); next_line();
        checks++;
        if (r_out !== 8'd192 || r4_out !== 4'd12) begin
            errors++;
            $display("FAIL lvl1 got %0d/%0d want 192/12", r_out, r4_out);
        end
        start_frame(2'd2); next_line();
        checks++;
        if (r_out !== 8'd127 || r4_out !== 4'd7) begin
            errors++;
            $display("FAIL lvl2 got %0d/%0d want 127/7", r_out, r4_out);
        end
        start_frame(2'd3); next_line();
        checks++;
        if ({r_out, g_out, b_out} !== {3{8'd63}} || {r4_out, g4_out, b4_out} !== {3{4'd3}}) begin
            errors++;
            $display("FAIL lvl3 got %0d/%0d want 63/3", r_out, r4_out);
        end
    endtask

    task automatic test_midframe_change();
        set_colour(8'd255, 4'd15);
        start_frame(2'd1); next_line();
        scanlines = 2'd3;
        next_line(); next_line();
        checks++;
        if (r_out !== 8'd192) begin
            errors++;
            $display("FAIL midframe_hold got %0d want 192", r_out);
        end
        start_frame(2'd3); next_line();
        checks++;
        if (r_out !== 8'd63) begin
            errors++;
            $display("FAIL next_frame_level got %0d want 63", r_out);
        end
    endtask

    task automatic test_blank_freeze();
        set_colour(8'd255, 4'd15);
        start_frame(2'd0);
        for (int i = 0; i < 8; i++) begin
            logic in_win;
            hb_in = (i < 4);
            en();
            in_win = (i >= 1 && i <= 4);
            checks++;
            if (hb_out !== in_win || r_out !== (in_win ? 8'd0 : 8'd255)
                || b4_out !== (in_win ? 4'd0 : 4'd15)) begin
                errors++;
                $display("FAIL hblank step %0d got hb=%b r=%0d b4=%0d want hb=%b",
                         i, hb_out, r_out, b4_out, in_win);
            end
        end
        hb_in = 1'b0;
        en();
        ce_pix = 1'b0;
        set_colour(8'd10, 4'd1);
        hb_in = 1'b1; vb_in = 1'b1; hs_in = 1'b1; vs_in = 1'b1;
        for (int i = 0; i < 5; i++) en();
        checks++;
        if (r_out !== 8'd255 || hb_out !== 1'b0 || vb_out !== 1'b0 || hs_out !== 1'b0
            || line_odd !== 1'b0) begin
            errors++;
            $display("FAIL freeze got r=%0d hb=%b vb=%b hs=%b lo=%b want 255/0/0/0/0",
                     r_out, hb_out, vb_out, hs_out, line_odd);
        end
        ce_pix = 1'b1;
        hb_in = 1'b0; vb_in = 1'b1; hs_in = 1'b0; vs_in = 1'b0;
        en(); en();
        checks++;
        if (vb_out !== 1'b1 || r_out !== 8'd0) begin
            errors++;
            $display("FAIL vblank got vb=%b r=%0d want 1/0", vb_out, r_out);
        end
        vb_in = 1'b0;
        set_colour(8'd255, 4'd15);
        en(); en();
    endtask

    task automatic test_coincident();
        start_frame(2'd2); next_line();
        checks++;
        if (line_odd !== 1'b1) begin
            errors++;
            $display("FAIL coincident_setup got %b want 1", line_odd);
        end
        hs_in = 1'b1; en();
        hs_in = 1'b0; vs_in = 1'b1; en();
        checks++;
        if (line_odd !== 1'b0) begin
            errors++;
            $display("FAIL coincident_vs_wins got %b want 0", line_odd);
        end
        vs_in = 1'b0; en();
    endtask

    task automatic test_reset_mid();
        set_colour(8'd200, 4'd15);
        start_frame(2'd3); next_line();
        @(posedge clk_sys); #2;
        reset_n = 1'b0;
        #1;
        checks++;
        if ({hs_out, vs_out, hb_out, vb_out, line_odd, r_out, g_out, b_out, r4_out} !== 33'd0) begin
            errors++;
            $display("FAIL async_reset got r=%0d lo=%b want 0", r_out, line_odd);
        end
        en();
        reset_n = 1'b1;
        scanlines = 2'd3;
        next_line();
        checks++;
        if (line_odd !== 1'b1 || r_out !== 8'd200) begin
            errors++;
            $display("FAIL post_reset_nodim got lo=%b r=%0d want 1/200", line_odd, r_out);
        end
        reset_n = 1'b0;
        vs_in = 1'b1; scanlines = 2'd2;
        en();
        reset_n = 1'b1;
        en();
        vs_in = 1'b0;
        next_line();
        checks++;
        if (r_out !== 8'd100) begin
            errors++;
            $display("FAIL first_enable_vs got %0d want 100", r_out);
        end
    endtask

    initial begin
        test_reset();
        test_no_vs();
        test_lvl2_lines();
        test_levels();
        test_midframe_change();
        test_blank_freeze();
        test_coincident();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
